// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared types and helpers for the AXI4-Lite register file:
//   resp_t      - AXI response codes
//   wr_state_t  - write-channel FSM states (W_IDLE, W_RESP)
//   rd_state_t  - read-channel FSM states (R_IDLE, R_DATA)
//   apply_wstrb - byte-lane merge of write data into an existing word
// -----------------------------------------------------------------------------
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Byte k of the result takes data[8k+7:8k] where strb[k] is set, else keeps old.
    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_v,
        input logic [31:0] data_v,
        input logic [3:0]  strb_v
    );
        logic [31:0] res_v;
        res_v = old_v;
        for (int k = 0; k < 4; k++) begin
            if (strb_v[k]) begin
                res_v[8*k +: 8] = data_v[8*k +: 8];
            end else begin
                res_v[8*k +: 8] = old_v[8*k +: 8];
            end
        end
        return res_v;
    endfunction

endpackage

// File: rtl/axil_slave_regfile.sv
// -----------------------------------------------------------------------------
// axil_slave_regfile
// AXI4-Lite slave holding NUM_REGS 32-bit read/write control registers.
// Write (AW/W/B) and read (AR/R) channels run independent two-state FSMs.
// Unmapped offsets answer SLVERR; unmapped reads return zero data.
//
// Ports:
//   aclk, areset        - clock, asynchronous active-high reset
//   s_axil_aw*/w*/b*    - AXI4-Lite write address / data / response channels
//   s_axil_ar*/r*       - AXI4-Lite read address / data channels
//   reg_q               - current contents of every register
//   reg_wr              - one-cycle pulse per register, high the cycle after
//                         that register was written (same cycle bvalid rises)
// -----------------------------------------------------------------------------
module axil_slave_regfile
    import axil_pkg::*;
#(
    parameter int          AXI_DATA_WIDTH = 32,
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          NUM_REGS       = 16,
    parameter logic [31:0] RESET_VAL      = 32'h0000_0000
) (
    input  logic                        aclk,
    input  logic                        areset,

    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                        s_axil_awvalid,
    output logic                        s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                        s_axil_wvalid,
    output logic                        s_axil_wready,
    output logic [1:0]                  s_axil_bresp,
    output logic                        s_axil_bvalid,
    input  logic                        s_axil_bready,

    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                        s_axil_arvalid,
    output logic                        s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                  s_axil_rresp,
    output logic                        s_axil_rvalid,
    input  logic                        s_axil_rready,

    output logic [AXI_DATA_WIDTH-1:0]   reg_q [NUM_REGS],
    output logic [NUM_REGS-1:0]         reg_wr
);

    // The decoded index is one bit wider than strictly needed for a
    // power-of-two register count, so the first alias above the register
    // block (e.g. offset 0x40 with 16 registers) decodes as unmapped instead
    // of wrapping onto register 0. For other counts this equals clog2(NUM_REGS).
    localparam int              IDX_W      = $clog2(NUM_REGS + 1);
    localparam int              SEL_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W:0]  NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

    // Register storage
    logic [AXI_DATA_WIDTH-1:0]  reg_q_r [NUM_REGS];
    logic [NUM_REGS-1:0]        reg_wr_r;

    // Write channel state
    wr_state_t                  wr_state_r;
    logic                       awready_r;
    logic                       wready_r;
    logic                       aw_held_r;
    logic                       w_held_r;
    logic [IDX_W-1:0]           awidx_r;
    logic [AXI_DATA_WIDTH-1:0]  wdata_r;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_r;
    logic                       bvalid_r;
    resp_t                      bresp_r;

    // Read channel state
    rd_state_t                  rd_state_r;
    logic                       arready_r;
    logic                       rvalid_r;
    resp_t                      rresp_r;
    logic [AXI_DATA_WIDTH-1:0]  rdata_r;

    // Combinational helpers
    logic                       aw_fire_s;
    logic                       w_fire_s;
    logic                       commit_s;
    logic [IDX_W-1:0]           wr_idx_s;
    logic [SEL_W-1:0]           wr_sel_s;
    logic                       wr_mapped_s;
    logic [AXI_DATA_WIDTH-1:0]  wr_data_s;
    logic [AXI_DATA_WIDTH/8-1:0] wr_strb_s;
    logic                       ar_fire_s;
    logic [IDX_W-1:0]           rd_idx_s;
    logic [SEL_W-1:0]           rd_sel_s;
    logic                       rd_mapped_s;
    logic                       unused_addr_bits_s;

    // Base decode belongs to the interconnect and byte offset is ignored.
    assign unused_addr_bits_s = ^{s_axil_awaddr[AXI_ADDR_WIDTH-1:IDX_W+2], s_axil_awaddr[1:0],
                                  s_axil_araddr[AXI_ADDR_WIDTH-1:IDX_W+2], s_axil_araddr[1:0]};

    assign aw_fire_s = s_axil_awvalid & awready_r;
    assign w_fire_s  = s_axil_wvalid  & wready_r;

    // Pick write address/data from the held copy if captured earlier, else live.
    always_comb begin
        wr_idx_s  = s_axil_awaddr[IDX_W+1:2];
        wr_data_s = s_axil_wdata;
        wr_strb_s = s_axil_wstrb;
        if (aw_held_r) begin
            wr_idx_s = awidx_r;
        end else begin
            wr_idx_s = s_axil_awaddr[IDX_W+1:2];
        end
        if (w_held_r) begin
            wr_data_s = wdata_r;
            wr_strb_s = wstrb_r;
        end else begin
            wr_data_s = s_axil_wdata;
            wr_strb_s = s_axil_wstrb;
        end
    end

    assign wr_sel_s    = wr_idx_s[SEL_W-1:0];
    assign wr_mapped_s = ({1'b0, wr_idx_s} < NUM_REGS_L);
    // Commit once both halves are present, whether held or arriving this cycle.
    assign commit_s    = (wr_state_r == W_IDLE) & (aw_held_r | aw_fire_s) & (w_held_r | w_fire_s);

    assign ar_fire_s   = s_axil_arvalid & arready_r;
    assign rd_idx_s    = s_axil_araddr[IDX_W+1:2];
    assign rd_sel_s    = rd_idx_s[SEL_W-1:0];
    assign rd_mapped_s = ({1'b0, rd_idx_s} < NUM_REGS_L);

    // Write FSM: AW/W capture, register update, write strobe and B response.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_r <= W_IDLE;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            awidx_r    <= '0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            bvalid_r   <= 1'b0;
            bresp_r    <= OKAY;
            reg_wr_r   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q_r[i] <= RESET_VAL;
            end
        end else begin
            reg_wr_r <= '0;
            case (wr_state_r)
                W_IDLE: begin
                    if (commit_s) begin
                        if (wr_mapped_s) begin
                            reg_q_r[wr_sel_s]  <= apply_wstrb(reg_q_r[wr_sel_s], wr_data_s, wr_strb_s);
                            reg_wr_r[wr_sel_s] <= 1'b1;
                            bresp_r            <= OKAY;
                        end else begin
                            bresp_r            <= SLVERR;
                        end
                        bvalid_r   <= 1'b1;
                        awready_r  <= 1'b0;
                        wready_r   <= 1'b0;
                        aw_held_r  <= 1'b1;
                        w_held_r   <= 1'b1;
                        wr_state_r <= W_RESP;
                    end else begin
                        if (aw_fire_s) begin
                            aw_held_r <= 1'b1;
                            awidx_r   <= s_axil_awaddr[IDX_W+1:2];
                            awready_r <= 1'b0;
                        end
                        if (w_fire_s) begin
                            w_held_r <= 1'b1;
                            wdata_r  <= s_axil_wdata;
                            wstrb_r  <= s_axil_wstrb;
                            wready_r <= 1'b0;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        bvalid_r   <= 1'b0;
                        aw_held_r  <= 1'b0;
                        w_held_r   <= 1'b0;
                        awready_r  <= 1'b1;
                        wready_r   <= 1'b1;
                        wr_state_r <= W_IDLE;
                    end
                end
                default: begin
                    bvalid_r   <= 1'b0;
                    aw_held_r  <= 1'b0;
                    w_held_r   <= 1'b0;
                    awready_r  <= 1'b1;
                    wready_r   <= 1'b1;
                    wr_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: samples the register array at the AR handshake, holds R until accepted.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
            rresp_r    <= OKAY;
            rdata_r    <= '0;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (ar_fire_s) begin
                        // reg_q_r is read before any same-edge write lands: pre-write value.
                        if (rd_mapped_s) begin
                            rdata_r <= reg_q_r[rd_sel_s];
                            rresp_r <= OKAY;
                        end else begin
                            rdata_r <= '0;
                            rresp_r <= SLVERR;
                        end
                        rvalid_r   <= 1'b1;
                        arready_r  <= 1'b0;
                        rd_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axil_rready) begin
                        rvalid_r   <= 1'b0;
                        arready_r  <= 1'b1;
                        rd_state_r <= R_IDLE;
                    end
                end
                default: begin
                    rvalid_r   <= 1'b0;
                    arready_r  <= 1'b1;
                    rd_state_r <= R_IDLE;
                end
            endcase
        end
    end

    assign s_axil_awready = awready_r;
    assign s_axil_wready  = wready_r;
    assign s_axil_bvalid  = bvalid_r;
    assign s_axil_bresp   = bresp_r;
    assign s_axil_arready = arready_r;
    assign s_axil_rvalid  = rvalid_r;
    assign s_axil_rresp   = rresp_r;
    assign s_axil_rdata   = rdata_r;
    assign reg_q          = reg_q_r;
    assign reg_wr         = reg_wr_r;

endmodule
